motor_cmd_sequencer: RTL

// Sequences speed commands for the two motor channels driving the balance robot's H-bridge PWM stage.

---
 rtl/motor_cmd_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/motor_cmd_sequencer.sv
// Dual-motor speed command sequencer: slew-limits each channel's magnitude, inserts a
// zero-speed dead interval on reversals and forces a stop when commands go stale.
//
// state | meaning
// RUN   | magnitude ramps toward target (same sign, or sitting at 0)
// DRAIN | reversal pending: magnitude ramps down to 0
// DEAD  | held at 0 for DEAD_TICKS ticks, then the sign is switched
module motor_cmd_sequencer #(
    parameter int TICK_DIV   = 1000,
    parameter int STEP       = 4,
    parameter int DEAD_TICKS = 8,
    parameter int WDOG_TICKS = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_m1_sign,
    input  logic [6:0] cmd_m1_mag,
    input  logic       cmd_m2_sign,
    input  logic [6:0] cmd_m2_mag,
    output logic       motor1_sign,
    output logic [6:0] motor1_period,
    output logic       motor2_sign,
    output logic [6:0] motor2_period,
    output logic       update,
    output logic       wdog_fault
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int WW = $clog2(WDOG_TICKS + 1);
    localparam int DW = $clog2(DEAD_TICKS + 1);

    typedef enum logic [1:0] {RUN, DRAIN, DEAD} state_t;

    state_t        state    [2];
    logic          sign     [2];
    logic [6:0]    mag      [2];
    logic [DW-1:0] dead_cnt [2];
    logic          tgt_sign [2];
    logic [6:0]    tgt_mag  [2];
    logic          cmd_sign [2];
    logic [6:0]    cmd_mag  [2];

    logic [PW-1:0] presc;
    logic [WW-1:0] wdog_cnt;
    logic [15:0]   cur_out;
    logic [15:0]   prev_out;
    logic          tick;
    logic          accept;

    assign cmd_ready   = !reset;
    assign accept      = cmd_valid && cmd_ready;
    assign tick        = (presc == PW'(TICK_DIV - 1));
    assign cmd_sign[0] = cmd_m1_sign;
    assign cmd_sign[1] = cmd_m2_sign;
    assign cmd_mag[0]  = cmd_m1_mag;
    assign cmd_mag[1]  = cmd_m2_mag;

    assign motor1_sign   = sign[0];
    assign motor1_period = mag[0];
    assign motor2_sign   = sign[1];
    assign motor2_period = mag[1];
    assign cur_out       = {sign[0], mag[0], sign[1], mag[1]};

    // One slew step from cur toward tgt, done in 8 bits and clamped to the 7-bit range.
    function automatic logic [6:0] step_toward(input logic [6:0] cur, input logic [6:0] tgt);
        logic [7:0] c;
        logic [7:0] t;
        logic [7:0] d;
        logic [7:0] r;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        if (t > c) begin
            d = t - c;
            r = c + ((d > 8'(STEP)) ? 8'(STEP) : d);
        end else begin
            d = c - t;
            r = c - ((d > 8'(STEP)) ? 8'(STEP) : d);
        end
        if (r > 8'd127) r = 8'd127;
        return r[6:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            presc      <= '0;
            wdog_cnt   <= '0;
            wdog_fault <= 1'b0;
            prev_out   <= '0;
            update     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                state[i]    <= RUN;
                sign[i]     <= 1'b0;
                mag[i]      <= '0;
                dead_cnt[i] <= '0;
                tgt_sign[i] <= 1'b0;
                tgt_mag[i]  <= '0;
            end
        end else begin
            presc <= tick ? '0 : presc + PW'(1);

            // An accept on the expiry tick takes priority over the forced stop.
            if (accept) begin
                for (int i = 0; i < 2; i++) begin
                    tgt_sign[i] <= cmd_sign[i];
                    tgt_mag[i]  <= cmd_mag[i];
                end
                wdog_cnt   <= '0;
                wdog_fault <= 1'b0;
            end else if (tick && wdog_cnt == WW'(WDOG_TICKS - 1)) begin
                tgt_mag[0] <= '0;
                tgt_mag[1] <= '0;
                wdog_cnt   <= WW'(WDOG_TICKS);
                wdog_fault <= 1'b1;
            end else if (tick && wdog_cnt < WW'(WDOG_TICKS)) begin
                wdog_cnt <= wdog_cnt + WW'(1);
            end

            if (tick) begin
                for (int i = 0; i < 2; i++) begin
                    case (state[i])
                        RUN: begin
                            if (mag[i] == '0 && sign[i] != tgt_sign[i]) begin
                                state[i]    <= DEAD;
                                dead_cnt[i] <= '0;
                            end else if (sign[i] == tgt_sign[i]) begin
                                mag[i] <= step_toward(mag[i], tgt_mag[i]);
                            end else begin
                                state[i] <= DRAIN;
                            end
                        end
                        DRAIN: begin
                            if (sign[i] == tgt_sign[i]) begin
                                state[i] <= RUN;
                            end else begin
                                mag[i] <= step_toward(mag[i], 7'd0);
                                if (step_toward(mag[i], 7'd0) == '0) begin
                                    state[i]    <= DEAD;
                                    dead_cnt[i] <= '0;
                                end
                            end
                        end
                        DEAD: begin
                            mag[i] <= '0;
                            if (dead_cnt[i] == DW'(DEAD_TICKS - 1)) begin
                                sign[i]  <= tgt_sign[i];
                                state[i] <= RUN;
                            end else begin
                                dead_cnt[i] <= dead_cnt[i] + DW'(1);
                            end
                        end
                        default: state[i] <= RUN;
                    endcase
                end
            end

            prev_out <= cur_out;
            update   <= (cur_out != prev_out);
        end
    end
endmodule
